// File: rtl/mcpu_pkg.sv
// Shared definitions for the MCPU control path.
// Holds the default widths, the opcode constants, the register file command
// encodings (also used by the register file) and the state and
// instruction-class encodings used by the control FSM and its decoder.
package mcpu_pkg;

  localparam int WORD_SIZE    = 8;   // datapath width seen by sibling blocks
  localparam int OPERAND_SIZE = 12;
  localparam int OPCODE_SIZE  = 4;
  localparam int INSTR_SIZE   = OPCODE_SIZE + 3 * OPERAND_SIZE;
  localparam int MEM_TIMEOUT  = 15;  // max cycles spent waiting for mem_ack
  localparam int CNT_W        = 4;   // width of the MEM wait counter

  localparam logic [OPCODE_SIZE-1:0] OPC_NOP   = 4'd0;
  localparam logic [OPCODE_SIZE-1:0] OPC_ADD   = 4'd1;
  localparam logic [OPCODE_SIZE-1:0] OPC_SUB   = 4'd2;
  localparam logic [OPCODE_SIZE-1:0] OPC_AND   = 4'd3;
  localparam logic [OPCODE_SIZE-1:0] OPC_OR    = 4'd4;
  localparam logic [OPCODE_SIZE-1:0] OPC_MOV   = 4'd5;
  localparam logic [OPCODE_SIZE-1:0] OPC_LOAD  = 4'd6;
  localparam logic [OPCODE_SIZE-1:0] OPC_STORE = 4'd7;

  // Register file command encodings.
  localparam logic [1:0] CMD_NORMAL_EX      = 2'b00;
  localparam logic [1:0] CMD_MOV_INTERNAL   = 2'b01;
  localparam logic [1:0] CMD_LOAD_FROM_DATA = 2'b10;
  localparam logic [1:0] CMD_DO_NOTHING     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_MOV,
    CLS_LOAD,
    CLS_STORE,
    CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/mcpu_decoder.sv
// Combinational opcode decoder for the MCPU control FSM.
// Ports:
//   opcode    in   instruction opcode field
//   alu_op    out  ALU function (opcode for ADD/SUB/AND/OR, else 0)
//   regsetcmd out  register file command for this instruction
//   op_class  out  instruction class that steers the FSM
//   illegal   out  opcode is undefined
module mcpu_decoder
  import mcpu_pkg::*;
(
  input  logic [OPCODE_SIZE-1:0] opcode,
  output logic [OPCODE_SIZE-1:0] alu_op,
  output logic [1:0]             regsetcmd,
  output op_class_t              op_class,
  output logic                   illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    alu_op    = '0;
    regsetcmd = CMD_DO_NOTHING;
    op_class  = CLS_ILLEGAL;
    illegal   = 1'b1;
    case (opcode)
      OPC_NOP: begin
        op_class = CLS_NOP;
        illegal  = 1'b0;
      end
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
        alu_op    = opcode;
        regsetcmd = CMD_NORMAL_EX;
        op_class  = CLS_ALU;
        illegal   = 1'b0;
      end
      OPC_MOV: begin
        regsetcmd = CMD_MOV_INTERNAL;
        op_class  = CLS_MOV;
        illegal   = 1'b0;
      end
      OPC_LOAD: begin
        regsetcmd = CMD_LOAD_FROM_DATA;
        op_class  = CLS_LOAD;
        illegal   = 1'b0;
      end
      OPC_STORE: begin
        op_class = CLS_STORE;
        illegal  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mcpu_control_fsm.sv
// MCPU control FSM: accepts one instruction at a time from fetch, walks it
// through DECODE / EXECUTE / MEM / WB and drives the register file and data
// memory controls. All outputs come straight from flops.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   instr_valid/ready fetch handshake (ready only in IDLE)
//   instr             {opcode, op1, op2, op3}
//   op1, op2, op3     latched operand fields
//   alu_op            ALU function
//   mem_read/write    data memory request, held until mem_ack or timeout
//   mem_ack           data memory completion
//   regsetcmd         register file command
//   regsetwb          one-cycle register file write strobe
//   illegal           one-cycle pulse for an undefined opcode
//   mem_timeout       one-cycle pulse when the memory wait expires
module mcpu_control_fsm
  import mcpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [INSTR_SIZE-1:0]   instr,
  output logic [OPERAND_SIZE-1:0] op1,
  output logic [OPERAND_SIZE-1:0] op2,
  output logic [OPERAND_SIZE-1:0] op3,
  output logic [OPCODE_SIZE-1:0]  alu_op,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic                    mem_ack,
  output logic [1:0]              regsetcmd,
  output logic                    regsetwb,
  output logic                    illegal,
  output logic                    mem_timeout
);

  state_t                 state;
  logic [OPCODE_SIZE-1:0] opcode_q;
  logic [CNT_W-1:0]       mem_cnt;

  logic [OPCODE_SIZE-1:0] dec_alu_op;
  logic [1:0]             dec_cmd;
  op_class_t              dec_class;
  logic                   dec_illegal;

  // The latched opcode is held until the next transfer, so the decode is
  // valid in every state after DECODE as well.
  mcpu_decoder u_decoder (
    .opcode    (opcode_q),
    .alu_op    (dec_alu_op),
    .regsetcmd (dec_cmd),
    .op_class  (dec_class),
    .illegal   (dec_illegal)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      instr_ready <= 1'b1;
      opcode_q    <= '0;
      op1         <= '0;
      op2         <= '0;
      op3         <= '0;
      alu_op      <= '0;
      regsetcmd   <= CMD_DO_NOTHING;
      regsetwb    <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
      mem_cnt     <= '0;
    end else begin
      // Pulse outputs fall by default; states raise them for one cycle.
      regsetwb    <= 1'b0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;

      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            opcode_q    <= instr[INSTR_SIZE-1 -: OPCODE_SIZE];
            op1         <= instr[3*OPERAND_SIZE-1 -: OPERAND_SIZE];
            op2         <= instr[2*OPERAND_SIZE-1 -: OPERAND_SIZE];
            op3         <= instr[OPERAND_SIZE-1:0];
            instr_ready <= 1'b0;
            state       <= S_DECODE;
          end
        end

        S_DECODE: begin
          regsetcmd <= dec_cmd;
          alu_op    <= dec_alu_op;
          if (dec_illegal) begin
            illegal     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end else if (dec_class == CLS_NOP) begin
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end else begin
            state <= S_EXECUTE;
          end
        end

        S_EXECUTE: begin
          if (dec_class == CLS_LOAD || dec_class == CLS_STORE) begin
            mem_read  <= (dec_class == CLS_LOAD);
            mem_write <= (dec_class == CLS_STORE);
            mem_cnt   <= '0;
            state     <= S_MEM;
          end else begin
            regsetwb <= 1'b1;
            state    <= S_WB;
          end
        end

        S_MEM: begin
          // Ack is tested first so it wins over an expiry on the same edge.
          if (mem_ack) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (dec_class == CLS_LOAD) begin
              regsetwb <= 1'b1;
              state    <= S_WB;
            end else begin
              regsetcmd   <= CMD_DO_NOTHING;
              instr_ready <= 1'b1;
              state       <= S_IDLE;
            end
          end else if (mem_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            mem_timeout <= 1'b1;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            regsetcmd   <= CMD_DO_NOTHING;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end else begin
            mem_cnt <= mem_cnt + 1'b1;
          end
        end

        S_WB: begin
          regsetcmd   <= CMD_DO_NOTHING;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end

        default: begin
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
